// File: rtl/cfifo_sync_sink.sv
// rtl/cfifo_sync_sink.sv - clocked sink for a two-phase click-FIFO token stream
//
// Turns the two-phase drive/free token handshake from an asynchronous click-FIFO
// controller into a synchronous valid/ready stream. The incoming drive level is
// synchronized through a flop chain, and each synchronized transition pushes the
// bundled data word into a small circular buffer. The free acknowledge is
// withheld while the buffer is full and released when a pop makes room.
//
// Ports:
//   clk        sink clock
//   rstn       asynchronous active-low reset
//   i_drive    two-phase request; each transition is one token
//   o_free     two-phase acknowledge; each transition frees one token
//   i_data     bundled data, stable from i_drive transition to matching o_free
//   o_valid    head entry available
//   i_ready    downstream accepts head this cycle
//   o_data     head entry
//   o_count    buffer occupancy
//   o_overflow sticky flag: a token arrived while one was already outstanding
module cfifo_sync_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_drive,
  output logic                   o_free,
  input  logic [DATA_WIDTH-1:0]  i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic                  s1_q, s2_q, s3_q;
  logic                  s1_d, s2_d, s3_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  free_q, free_d;
  logic                  pend_q, pend_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic evt;
  logic push;
  logic pop;
  logic valid;

  // i_data is deliberately not synchronized: the bundling constraint keeps it
  // stable until o_free answers, which is well after evt is seen.
  assign evt   = s2_q ^ s3_q;
  assign valid = (count_q != '0);
  // A token arriving while pend is set means upstream ignored the withheld
  // credit; it is dropped rather than pushed.
  assign push  = evt & ~pend_q;
  assign pop   = valid & i_ready;

  always_comb begin
    s1_d       = i_drive;
    s2_d       = s1_q;
    s3_d       = s2_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    free_d     = free_q;
    pend_d     = pend_q;
    overflow_d = overflow_q | (evt & pend_q);
    mem_d      = mem_q;

    if (push) begin
      mem_d[wptr_q] = i_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // push and a pending release are mutually exclusive because push needs
    // pend_q low, so at most one free toggle happens per edge.
    if (push) begin
      if (count_d == FULL) begin
        pend_d = 1'b1;
      end else begin
        free_d = ~free_q;
      end
    end else if (pend_q && pop) begin
      free_d = ~free_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      free_q     <= 1'b0;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      free_q     <= free_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign o_free     = free_q;
  assign o_valid    = valid;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_data     = mem_q[rptr_q];

endmodule

// File: tb/tb_cfifo_sync_sink.sv
// tb/tb_cfifo_sync_sink.sv - directed scoreboard bench for cfifo_sync_sink
module tb_cfifo_sync_sink;

  logic        clk;
  logic        rstn;
  logic        i_drive;
  logic        o_free;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [2:0]  o_count;
  logic        o_overflow;

  int          passed;
  int          total;
  logic [31:0] exp_q[$];
  int          free_tog;
  logic        free_prev;
  logic        tog_en;
  int          tick_n;

  cfifo_sync_sink #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_drive    (i_drive),
    .o_free     (o_free),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard side: every accepted beat must match the oldest expected word.
  always @(negedge clk) begin
    if (rstn && o_valid && i_ready) begin
      if (exp_q.size() > 0) chk("pop_data", {32'h0, o_data}, {32'h0, exp_q.pop_front()});
      else                  chk("pop_unexpected", {32'h0, o_data}, 64'hFFFF_FFFF_0BAD_0BAD);
    end
    if (o_free !== free_prev) begin
      free_tog++;
      free_prev = o_free;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tick_n++;
    if (tog_en && (tick_n % 2 == 0)) i_ready = ~i_ready;
  endtask

  task automatic send(input logic [31:0] d, input bit expect_push);
    i_data  = d;
    i_drive = ~i_drive;
    if (expect_push) exp_q.push_back(d);
  endtask

  task automatic wait_free(input string tag);
    logic old;
    int   n;
    old = o_free;
    n   = 0;
    while (o_free === old && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {63'h0, (o_free !== old)}, 64'h1);
  endtask

  task automatic single_token(input string tag);
    logic old;
    i_ready = 1'b1;
    old = o_free;
    send(32'hA5A5_0001, 1'b1);
    tick();
    chk({tag, "_free_e0"}, {63'h0, o_free}, {63'h0, old});
    tick();
    chk({tag, "_free_e1"}, {63'h0, o_free}, {63'h0, old});
    tick();
    chk({tag, "_free_e2"}, {63'h0, o_free}, {63'h0, ~old});
    chk({tag, "_valid_e2"}, {63'h0, o_valid}, 64'h1);
    chk({tag, "_data_e2"}, {32'h0, o_data}, 64'hA5A5_0001);
    tick();
    chk({tag, "_valid_e3"}, {63'h0, o_valid}, 64'h0);
    chk({tag, "_count_e3"}, {61'h0, o_count}, 64'h0);
    i_ready = 1'b0;
  endtask

  initial begin
    int f0;
    logic fl;
    passed    = 0;
    total     = 0;
    free_tog  = 0;
    free_prev = 1'b0;
    tog_en    = 1'b0;
    tick_n    = 0;
    rstn      = 1'b0;
    i_drive   = 1'b0;
    i_data    = '0;
    i_ready   = 1'b0;

    repeat (3) tick();
    chk("rst_free", {63'h0, o_free}, 64'h0);
    chk("rst_valid", {63'h0, o_valid}, 64'h0);
    chk("rst_count", {61'h0, o_count}, 64'h0);
    chk("rst_overflow", {63'h0, o_overflow}, 64'h0);
    rstn = 1'b1;
    tick();

    // single token, three-edge latency
    single_token("single");

    // fill to full, fourth token held pending
    i_ready = 1'b0;
    f0 = free_tog;
    for (int i = 1; i <= 3; i++) begin
      send(32'(i), 1'b1);
      wait_free("fill_free");
    end
    send(32'h4, 1'b1);
    repeat (6) tick();
    chk("fill_toggles", 64'(free_tog - f0), 64'd3);
    chk("fill_count", {61'h0, o_count}, 64'd4);
    chk("fill_pend", {63'h0, dut.pend_q}, 64'h1);
    fl = o_free;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("pend_release_free", {63'h0, o_free}, {63'h0, ~fl});
    chk("pend_release_count", {61'h0, o_count}, 64'd3);
    chk("pend_release_pend", {63'h0, dut.pend_q}, 64'h0);
    i_ready = 1'b1;
    repeat (3) tick();
    i_ready = 1'b0;
    chk("fill_drain_count", {61'h0, o_count}, 64'd0);
    chk("fill_drain_sb", 64'(exp_q.size()), 64'd0);

    // simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) begin
      send(32'h10 + 32'(i), 1'b1);
      wait_free("sim_fill_free");
    end
    chk("sim_count_pre", {61'h0, o_count}, 64'd3);
    fl = o_free;
    send(32'h13, 1'b1);
    tick();
    tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("sim_count", {61'h0, o_count}, 64'd3);
    chk("sim_free", {63'h0, o_free}, {63'h0, ~fl});
    chk("sim_pend", {63'h0, dut.pend_q}, 64'h0);
    i_ready = 1'b1;
    repeat (4) tick();
    i_ready = 1'b0;
    chk("sim_drain_sb", 64'(exp_q.size()), 64'd0);

    // wrap-around stream with toggling ready
    f0 = free_tog;
    tog_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(32'(i), 1'b1);
      wait_free("wrap_free");
    end
    tog_en  = 1'b0;
    i_ready = 1'b1;
    repeat (12) tick();
    i_ready = 1'b0;
    tick();
    chk("wrap_toggles", 64'(free_tog - f0), 64'd10);
    chk("wrap_overflow", {63'h0, o_overflow}, 64'h0);
    chk("wrap_drain_sb", 64'(exp_q.size()), 64'd0);

    // protocol violation while pend is set
    for (int i = 0; i < 3; i++) begin
      send(32'h21 + 32'(i), 1'b1);
      wait_free("viol_fill_free");
    end
    send(32'h24, 1'b1);
    repeat (6) tick();
    chk("viol_pend", {63'h0, dut.pend_q}, 64'h1);
    send(32'hDEAD, 1'b0);
    repeat (6) tick();
    chk("viol_overflow", {63'h0, o_overflow}, 64'h1);
    chk("viol_count", {61'h0, o_count}, 64'd4);
    i_ready = 1'b1;
    repeat (6) tick();
    i_ready = 1'b0;
    chk("viol_drain_sb", 64'(exp_q.size()), 64'd0);
    chk("viol_sticky", {63'h0, o_overflow}, 64'h1);

    // reset mid-stream with two entries buffered
    for (int i = 0; i < 2; i++) begin
      send(32'h31 + 32'(i), 1'b1);
      wait_free("mid_fill_free");
    end
    chk("mid_count_pre", {61'h0, o_count}, 64'd2);
    rstn    = 1'b0;
    i_drive = 1'b0;
    #1;
    chk("mid_rst_free", {63'h0, o_free}, 64'h0);
    chk("mid_rst_valid", {63'h0, o_valid}, 64'h0);
    chk("mid_rst_count", {61'h0, o_count}, 64'h0);
    chk("mid_rst_overflow", {63'h0, o_overflow}, 64'h0);
    exp_q.delete();
    tick();
    rstn = 1'b1;
    tick();
    single_token("after_rst");
    repeat (2) tick();
    chk("final_sb", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
